// File: rtl/mem_stage_access_pkg.sv
// rtl/mem_stage_access_pkg.sv - shared types, funct3 codes and alignment helper for the MEM stage
package mem_stage_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // funct3[1:0] encodes access size for both loads and stores
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_HALF: mis = a[0];
            SZ_WORD: mis = (a != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_access_load_align.sv
// rtl/mem_stage_access_load_align.sv - selects and extends the addressed byte/half of a load word
module load_align_ext
    import mem_stage_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  a,
    output logic [31:0] read_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = 8'h00;
        case (a)
            2'b00:   sel_byte = rdata[7:0];
            2'b01:   sel_byte = rdata[15:8];
            2'b10:   sel_byte = rdata[23:16];
            default: sel_byte = rdata[31:24];
        endcase
        sel_half = a[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        read_data = rdata;
        case (funct3)
            F3_LB:   read_data = {{24{sel_byte[7]}}, sel_byte};
            F3_LH:   read_data = {{16{sel_half[15]}}, sel_half};
            F3_LW:   read_data = rdata;
            F3_LBU:  read_data = {24'h000000, sel_byte};
            F3_LHU:  read_data = {16'h0000, sel_half};
            default: read_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_access.sv
// rtl/mem_stage_access.sv - MEM stage: data-bus load/store handshake, stall generation and MEM/WB register
module mem_stage_access
    import mem_stage_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_MEM,
    input  logic        mem_write_MEM,
    input  logic [2:0]  funct3_MEM,
    input  logic [31:0] address_MEM,
    input  logic [31:0] write_data_MEM,
    input  logic        RegWrite_MEM,
    input  logic        MemtoReg_MEM,
    input  logic [4:0]  RD_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] read_data_WB,
    output logic [31:0] address_WB,
    output logic        RegWrite_WB,
    output logic        MemtoReg_WB,
    output logic [4:0]  RD_WB,
    output logic        misalign_err,
    output logic        bus_err
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             access, misaligned, timed_out;
    logic             req_c, stall_c;
    logic             wb_load, wb_kill, mis_pulse, bus_pulse;
    logic [3:0]       st_strb;
    logic [31:0]      st_data;
    logic [31:0]      load_aligned;

    assign access     = mem_read_MEM | mem_write_MEM;
    assign misaligned = is_misaligned(funct3_MEM[1:0], address_MEM[1:0]);
    assign timed_out  = (cnt == CNT_W'(TIMEOUT_CYCLES));

    // Store lane placement: data is replicated so the slave can pick any enabled lane
    always_comb begin
        st_strb = 4'b1111;
        st_data = write_data_MEM;
        case (funct3_MEM[1:0])
            SZ_BYTE: begin
                st_strb = 4'b0001 << address_MEM[1:0];
                st_data = {4{write_data_MEM[7:0]}};
            end
            SZ_HALF: begin
                st_strb = address_MEM[1] ? 4'b1100 : 4'b0011;
                st_data = {2{write_data_MEM[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = write_data_MEM;
            end
        endcase
    end

    assign dmem_addr  = {address_MEM[31:2], 2'b00};
    assign dmem_we    = mem_write_MEM;
    assign dmem_wdata = st_data;
    assign dmem_wstrb = mem_write_MEM ? st_strb : 4'b0000;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == ST_IDLE) ? '0 : cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        req_c     = 1'b0;
        stall_c   = 1'b0;
        wb_load   = 1'b0;
        wb_kill   = 1'b0;
        mis_pulse = 1'b0;
        bus_pulse = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        wb_load   = 1'b1;
                        wb_kill   = 1'b1;
                        mis_pulse = 1'b1;
                    end else begin
                        req_c     = 1'b1;
                        stall_c   = 1'b1;
                        state_nxt = dmem_gnt ? ST_RESP : ST_REQ;
                    end
                end else begin
                    wb_load = 1'b1;
                end
            end
            ST_REQ: begin
                if (timed_out) begin
                    wb_load   = 1'b1;
                    wb_kill   = 1'b1;
                    bus_pulse = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    if (dmem_gnt) state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                // A response arriving on the timeout cycle still completes the access
                if (dmem_rvalid) begin
                    wb_load   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (timed_out) begin
                    wb_load   = 1'b1;
                    wb_kill   = 1'b1;
                    bus_pulse = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Keep the bus and pipeline quiet while reset is held, even with an access presented
    assign dmem_req = req_c & reset;
    assign stall    = stall_c & reset;

    load_align_ext u_load_align (
        .rdata     (dmem_rdata),
        .funct3    (funct3_MEM),
        .a         (address_MEM[1:0]),
        .read_data (load_aligned)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data_WB <= '0;
            address_WB   <= '0;
            RegWrite_WB  <= 1'b0;
            MemtoReg_WB  <= 1'b0;
            RD_WB        <= '0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            misalign_err <= mis_pulse;
            bus_err      <= bus_pulse;
            if (wb_load) begin
                read_data_WB <= load_aligned;
                address_WB   <= address_MEM;
                RegWrite_WB  <= RegWrite_MEM & ~wb_kill;
                MemtoReg_WB  <= MemtoReg_MEM;
                RD_WB        <= RD_MEM;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_access.sv
// tb/tb_mem_stage_access.sv - randomized self-checking bench for mem_stage_access
module tb_mem_stage_access;

    localparam int TIMEOUT = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_MEM, mem_write_MEM;
    logic [2:0]  funct3_MEM;
    logic [31:0] address_MEM, write_data_MEM;
    logic        RegWrite_MEM, MemtoReg_MEM;
    logic [4:0]  RD_MEM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] read_data_WB, address_WB;
    logic        RegWrite_WB, MemtoReg_WB;
    logic [4:0]  RD_WB;
    logic        misalign_err, bus_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage_access #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(9)) dut (
        .clk(clk), .reset(reset),
        .mem_read_MEM(mem_read_MEM), .mem_write_MEM(mem_write_MEM),
        .funct3_MEM(funct3_MEM), .address_MEM(address_MEM), .write_data_MEM(write_data_MEM),
        .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM), .RD_MEM(RD_MEM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .stall(stall), .read_data_WB(read_data_WB), .address_WB(address_WB),
        .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB), .RD_WB(RD_WB),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // Load reference: shift the word down, mask to the access size, sign-correct arithmetically
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int     sz;
        longint v;
        sz = size_of(f3);
        v  = longint'({32'h0, word} >> (8 * addr[1:0])) & ((64'd1 << (8 * sz)) - 1);
        if (!f3[2] && sz < 4 && v >= (64'd1 << (8 * sz - 1)))
            v = v - (64'd1 << (8 * sz));
        return v[31:0];
    endfunction

    // Store reference: lane i is enabled when it falls inside [a, a+size); its byte is source byte i mod size
    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                             output logic [3:0] strb, output logic [31:0] data);
        int sz, a;
        sz = size_of(f3);
        a  = int'(addr[1:0]);
        for (int i = 0; i < 4; i++) begin
            strb[i]       = (i >= a) && (i < a + sz);
            data[8*i +: 8] = wd[8*(i % sz) +: 8];
        end
    endtask

    // Runs one access from posedge+1 until the MEM/WB register captures it, acting as the bus slave.
    // gd: request cycles before gnt; rv: RESP cycles before rvalid (<0 = never).
    task automatic run_access(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                              input int gd, input int rv, input bit to_exp);
        logic        rw, m2r;
        logic [4:0]  rdd;
        logic [3:0]  e_strb;
        logic [31:0] e_data;
        bit          mis, granted, done;
        int          stalls, reqs, resp_cnt, req_seen, cyc, exp_stalls;
        rw = 1'($urandom); m2r = 1'($urandom); rdd = 5'($urandom);
        mis = (addr % size_of(f3)) != 0;
        mem_read_MEM = rd; mem_write_MEM = wr; funct3_MEM = f3;
        address_MEM = addr; write_data_MEM = wd;
        RegWrite_MEM = rw; MemtoReg_MEM = m2r; RD_MEM = rdd;
        granted = 0; done = 0; stalls = 0; reqs = 0; resp_cnt = 0; req_seen = 0; cyc = 0;
        while (!done) begin
            #1;
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = rdat;
            if (granted) begin
                if (rv >= 0 && resp_cnt == rv) dmem_rvalid = 1'b1;
                resp_cnt++;
            end else if (dmem_req) begin
                if (reqs == gd) dmem_gnt = 1'b1;
                reqs++;
            end
            #1;
            if (dmem_req) req_seen++;
            if (cyc == 0 && !mis) begin
                check({tag, ":req"}, dmem_req, 1'b1);
                check({tag, ":addr"}, dmem_addr, {addr[31:2], 2'b00});
                check({tag, ":we"}, dmem_we, wr);
                if (wr) begin
                    ref_store(f3, addr, wd, e_strb, e_data);
                    check({tag, ":wstrb"}, dmem_wstrb, e_strb);
                    check({tag, ":wdata"}, dmem_wdata, e_data);
                end else begin
                    check({tag, ":wstrb_ld"}, dmem_wstrb, 4'b0000);
                end
            end
            if (dmem_gnt) granted = 1;
            if (stall) stalls++; else done = 1;
            cyc++;
            if (cyc > TIMEOUT + 20) begin
                check({tag, ":hang"}, 32'(cyc), 32'(TIMEOUT + 2));
                done = 1;
            end
            @(posedge clk);
        end
        #1;
        exp_stalls = mis ? 0 : to_exp ? TIMEOUT + 1 : gd + 1 + rv;
        check({tag, ":stalls"}, 32'(stalls), 32'(exp_stalls));
        if (mis) check({tag, ":no_req"}, 32'(req_seen), 32'd0);
        check({tag, ":rw_wb"}, RegWrite_WB, (mis || to_exp) ? 1'b0 : rw);
        check({tag, ":m2r_wb"}, MemtoReg_WB, m2r);
        check({tag, ":rd_wb"}, RD_WB, rdd);
        check({tag, ":addr_wb"}, address_WB, addr);
        check({tag, ":mis_err"}, misalign_err, mis);
        check({tag, ":bus_err"}, bus_err, to_exp);
        if (rd && !mis && !to_exp)
            check({tag, ":rdata_wb"}, read_data_WB, ref_load(f3, addr, rdat));
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    // One cycle with no access; any bus handshake seen now must be ignored
    task automatic idle_cycle(input string tag, input bit gnt, input bit rvalid);
        logic        rw;
        logic [31:0] addr;
        rw = 1'($urandom); addr = $urandom;
        mem_read_MEM = 0; mem_write_MEM = 0; address_MEM = addr;
        RegWrite_MEM = rw; MemtoReg_MEM = 0; RD_MEM = 5'($urandom);
        #1;
        dmem_gnt = gnt; dmem_rvalid = rvalid; dmem_rdata = $urandom;
        #1;
        check({tag, ":idle_stall"}, stall, 1'b0);
        check({tag, ":idle_req"}, dmem_req, 1'b0);
        @(posedge clk);
        #1;
        check({tag, ":idle_rw"}, RegWrite_WB, rw);
        check({tag, ":idle_addr"}, address_WB, addr);
        check({tag, ":idle_bus_err"}, bus_err, 1'b0);
        dmem_gnt = 0; dmem_rvalid = 0;
    endtask

    initial begin
        logic [2:0] f3;
        bit         ld;
        reset = 0;
        mem_read_MEM = 0; mem_write_MEM = 0; funct3_MEM = 0; address_MEM = 0;
        write_data_MEM = 0; RegWrite_MEM = 0; MemtoReg_MEM = 0; RD_MEM = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst:stall", stall, 1'b0);
        check("rst:req", dmem_req, 1'b0);
        check("rst:rw_wb", RegWrite_WB, 1'b0);
        check("rst:rdata_wb", read_data_WB, 32'h0);
        check("rst:errs", {misalign_err, bus_err}, 2'b00);
        reset = 1;
        @(posedge clk); #1;

        run_access("sw", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 0);
        run_access("lb", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FFFF7F, 0, 0, 0);
        check("lb:value", read_data_WB, 32'hFFFFFF80);
        run_access("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FFFF7F, 0, 0, 0);
        check("lbu:value", read_data_WB, 32'h00000080);
        run_access("sh", 0, 1, 3'b001, 32'h102, 32'h1234, 32'h0, 3, 0, 0);
        run_access("lw_mis", 1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 0);
        idle_cycle("after_mis", 0, 0);
        check("mis:pulse_1cyc", misalign_err, 1'b0);
        run_access("lw_to", 1, 0, 3'b010, 32'h200, 32'h0, 32'h0, 0, -1, 1);
        idle_cycle("stray", 0, 1);
        idle_cycle("stray_gnt", 1, 1);

        // Reset while waiting in RESP
        mem_read_MEM = 1; mem_write_MEM = 0; funct3_MEM = 3'b010; address_MEM = 32'h300;
        RegWrite_MEM = 1; MemtoReg_MEM = 1; RD_MEM = 5'd7;
        #1; dmem_gnt = 1;
        @(posedge clk); #1;
        dmem_gnt = 0;
        reset = 0;
        #1;
        check("rst_resp:stall", stall, 1'b0);
        check("rst_resp:req", dmem_req, 1'b0);
        check("rst_resp:wb", {RegWrite_WB, MemtoReg_WB, RD_WB}, 7'h0);
        check("rst_resp:addr_wb", address_WB, 32'h0);
        @(posedge clk); #1;
        reset = 1;
        run_access("lw_post_rst", 1, 0, 3'b010, 32'h304, 32'h0, 32'hCAFEF00D, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            ld = 1'($urandom);
            if (ld) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 2));
            end
            run_access($sformatf("rnd%0d", i), ld, !ld, f3, $urandom, $urandom, $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 3), 0);
            if ($urandom_range(0, 3) == 0) idle_cycle($sformatf("rndidle%0d", i), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
